// File: rtl/maze_pkg.sv
// Shared types for the wall-following maze walker.
//   heading_e      : walking direction, 0=up 1=right 2=down 3=left
//   state_e        : walker FSM states
//   offset_t       : signed row/col step for one heading
//   heading_offset : heading -> offset_t
package maze_pkg;

    typedef enum logic [1:0] {
        HdUp    = 2'd0,
        HdRight = 2'd1,
        HdDown  = 2'd2,
        HdLeft  = 2'd3
    } heading_e;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StProbe,
        StEval,
        StDone,
        StFail
    } state_e;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } offset_t;

    function automatic offset_t heading_offset(heading_e h);
        offset_t o;
        o.dr = 2'sd0;
        o.dc = 2'sd0;
        unique case (h)
            HdUp:    o.dr = -2'sd1;
            HdRight: o.dc = 2'sd1;
            HdDown:  o.dr = 2'sd1;
            HdLeft:  o.dc = -2'sd1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/maze_walker_if.sv
// Host/RAM-facing signal bundle of the maze walker.
//   slave  : walker side (takes start/coords/maze_in, drives address, strobes, status)
//   master : host + RAM side
interface maze_walker_if #(
    parameter int unsigned MAZE_W = 6,
    parameter int unsigned STEP_W = 12
);
    logic              start;
    logic              hand_sel;
    logic [MAZE_W-1:0] starting_row;
    logic [MAZE_W-1:0] starting_col;
    logic              maze_in;
    logic [MAZE_W-1:0] row;
    logic [MAZE_W-1:0] col;
    logic              maze_oe;
    logic              maze_we;
    logic              busy;
    logic              done;
    logic              fail;
    logic [STEP_W-1:0] step_cnt;

    modport slave (
        input  start, hand_sel, starting_row, starting_col, maze_in,
        output row, col, maze_oe, maze_we, busy, done, fail, step_cnt
    );

    modport master (
        output start, hand_sel, starting_row, starting_col, maze_in,
        input  row, col, maze_oe, maze_we, busy, done, fail, step_cnt
    );
endinterface

// File: rtl/maze_dir_sel.sv
// Probe direction selector (combinational).
//   heading_i : current heading
//   hand_i    : 0 = right-hand rule, 1 = left-hand rule
//   k_i       : probe index 0..3
//   dir_o     : direction to probe
module maze_dir_sel
    import maze_pkg::*;
(
    input  heading_e   heading_i,
    input  logic       hand_i,
    input  logic [1:0] k_i,
    output heading_e   dir_o
);
    logic [1:0] rot;

    // Rotation added to the heading (mod 4): right-hand +1,0,-1,+2; left-hand mirrored.
    always_comb begin
        unique case (k_i)
            2'd0:    rot = hand_i ? 2'd3 : 2'd1;
            2'd1:    rot = 2'd0;
            2'd2:    rot = hand_i ? 2'd1 : 2'd3;
            default: rot = 2'd2;
        endcase
        dir_o = heading_e'(heading_i + rot);
    end
endmodule

// File: rtl/maze_walker.sv
// Wall-follower maze walker between a control host and a synchronous maze RAM.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : maze_walker_if.slave (start handshake, RAM address/strobes, status)
// Marks each entered cell, probes neighbours in hand-rule order and stops on a
// border cell (done), when boxed in, or when the step counter would saturate (fail).
module maze_walker
    import maze_pkg::*;
#(
    parameter int unsigned MAZE_W   = 6,
    parameter int unsigned MAZE_DIM = 64,
    parameter int unsigned STEP_W   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    maze_walker_if.slave  bus
);
    localparam logic [MAZE_W-1:0] LastIdx = MAZE_W'(MAZE_DIM - 1);
    localparam logic [STEP_W-1:0] StepMax = {STEP_W{1'b1}};

    state_e            state_q, state_d;
    logic [MAZE_W-1:0] cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [MAZE_W-1:0] row_q, row_d, col_q, col_d;
    heading_e          heading_q, heading_d, dir_q, dir_d;
    logic              hand_q, hand_d;
    logic [1:0]        k_q, k_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic [1:0]        probe_k;
    heading_e          probe_dir;
    offset_t           probe_off;
    logic [MAZE_W-1:0] probe_row, probe_col;
    logic              on_border;

    // Index of the probe about to be issued: restart at 0 after MARK, else next one.
    assign probe_k = (state_q == StEval) ? k_q + 2'd1 : 2'd0;

    maze_dir_sel u_dir_sel (
        .heading_i (heading_q),
        .hand_i    (hand_q),
        .k_i       (probe_k),
        .dir_o     (probe_dir)
    );

    assign probe_off = heading_offset(probe_dir);
    assign probe_row = cur_row_q + MAZE_W'(probe_off.dr);
    assign probe_col = cur_col_q + MAZE_W'(probe_off.dc);
    assign on_border = (cur_row_q == '0) || (cur_row_q == LastIdx) ||
                       (cur_col_q == '0) || (cur_col_q == LastIdx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_row_q <= '0;
            cur_col_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            heading_q <= HdUp;
            dir_q     <= HdUp;
            hand_q    <= 1'b0;
            k_q       <= 2'd0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            row_q     <= row_d;
            col_q     <= col_d;
            heading_q <= heading_d;
            dir_q     <= dir_d;
            hand_q    <= hand_d;
            k_q       <= k_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        row_d     = row_q;
        col_d     = col_q;
        heading_d = heading_q;
        dir_d     = dir_q;
        hand_d    = hand_q;
        k_d       = k_q;
        step_d    = step_q;
        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (bus.start) begin
                    state_d   = StMark;
                    cur_row_d = bus.starting_row;
                    cur_col_d = bus.starting_col;
                    row_d     = bus.starting_row;
                    col_d     = bus.starting_col;
                    hand_d    = bus.hand_sel;
                    heading_d = HdUp;
                    step_d    = '0;
                end
            end
            StMark: begin
                if (on_border) begin
                    state_d = StDone;
                end else begin
                    state_d = StProbe;
                    k_d     = probe_k;
                    dir_d   = probe_dir;
                    row_d   = probe_row;
                    col_d   = probe_col;
                end
            end
            StProbe: state_d = StEval;
            StEval: begin
                if (!bus.maze_in) begin
                    // row_q/col_q still hold the probed (open) cell
                    if (step_q == StepMax - 1'b1) begin
                        step_d  = StepMax;
                        state_d = StFail;
                    end else begin
                        step_d    = step_q + 1'b1;
                        state_d   = StMark;
                        cur_row_d = row_q;
                        cur_col_d = col_q;
                        heading_d = dir_q;
                    end
                end else if (k_q == 2'd3) begin
                    state_d = StFail;
                end else begin
                    state_d = StProbe;
                    k_d     = probe_k;
                    dir_d   = probe_dir;
                    row_d   = probe_row;
                    col_d   = probe_col;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.maze_we  = (state_q == StMark);
        bus.maze_oe  = (state_q == StProbe);
        bus.busy     = (state_q == StMark) || (state_q == StProbe) || (state_q == StEval);
        bus.done     = (state_q == StDone);
        bus.fail     = (state_q == StFail);
        bus.row      = row_q;
        bus.col      = col_q;
        bus.step_cnt = step_q;
    end
endmodule

// File: tb/tb_maze_walker.sv
module tb_maze_walker;
    import maze_pkg::*;

    localparam int W = 3;
    localparam int D = 8;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maze_walker_if #(.MAZE_W(W), .STEP_W(S)) bus ();

    maze_walker #(.MAZE_W(W), .MAZE_DIM(D), .STEP_W(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit wall [D][D];
    int act_we[$];
    int act_oe[$];
    int exp_we[$];
    int exp_oe[$];
    int overlap = 0;
    bit m_done;
    int m_step;

    // Synchronous RAM (data valid the cycle after maze_oe) and strobe monitor.
    always @(negedge clk) begin
        if (bus.maze_oe) begin
            bus.maze_in = wall[bus.row][bus.col];
            act_oe.push_back(int'(bus.row) * D + int'(bus.col));
        end
        if (bus.maze_we) act_we.push_back(int'(bus.row) * D + int'(bus.col));
        if (bus.maze_oe && bus.maze_we) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_maze(input int id);
        for (int r = 0; r < D; r++) for (int c = 0; c < D; c++) wall[r][c] = 1'b0;
        if (id == 2) begin
            wall[1][2] = 1'b1; wall[2][3] = 1'b1; wall[3][2] = 1'b1; wall[2][1] = 1'b1;
        end else if (id == 3) begin
            for (int c = 1; c < D - 1; c++) begin
                wall[2][c] = 1'b1;
                wall[4][c] = 1'b1;
            end
        end
    endtask

    // Reference walker: hand rule as rotations relative to the heading.
    task automatic model_walk(input int sr, input int sc, input bit hand);
        int dr[4] = '{-1, 0, 1, 0};
        int dc[4] = '{0, 1, 0, -1};
        int rot_r[4] = '{1, 0, 3, 2};
        int rot_l[4] = '{3, 0, 1, 2};
        int r = sr, c = sc, h = 0, d, nr, nc;
        bit moved;
        exp_we.delete();
        exp_oe.delete();
        m_done = 1'b0;
        m_step = 0;
        for (int it = 0; it < 64; it++) begin
            exp_we.push_back(r * D + c);
            if (r == 0 || r == D - 1 || c == 0 || c == D - 1) begin
                m_done = 1'b1;
                return;
            end
            moved = 1'b0;
            for (int k = 0; k < 4 && !moved; k++) begin
                d  = (h + (hand ? rot_l[k] : rot_r[k])) % 4;
                nr = r + dr[d];
                nc = c + dc[d];
                exp_oe.push_back(nr * D + nc);
                if (!wall[nr][nc]) begin
                    m_step++;
                    if (m_step == (1 << S) - 1) return;
                    r = nr; c = nc; h = d;
                    moved = 1'b1;
                end
            end
            if (!moved) return;
        end
    endtask

    task automatic pulse_start(input int sr, input int sc, input bit hand);
        @(negedge clk);
        bus.starting_row = W'(sr);
        bus.starting_col = W'(sc);
        bus.hand_sel     = hand;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".finished"}, 32'(n < 500), 32'd1);
    endtask

    task automatic compare_results(input string tag);
        int n;
        check({tag, ".done"}, 32'(bus.done), 32'(m_done));
        check({tag, ".fail"}, 32'(bus.fail), 32'(!m_done));
        check({tag, ".step"}, 32'(bus.step_cnt), 32'(m_step));
        check({tag, ".we_n"}, act_we.size(), exp_we.size());
        check({tag, ".oe_n"}, act_oe.size(), exp_oe.size());
        n = (act_we.size() < exp_we.size()) ? act_we.size() : exp_we.size();
        for (int i = 0; i < n; i++) check({tag, ".we_cell"}, act_we[i], exp_we[i]);
        n = (act_oe.size() < exp_oe.size()) ? act_oe.size() : exp_oe.size();
        for (int i = 0; i < n; i++) check({tag, ".oe_cell"}, act_oe[i], exp_oe[i]);
        if (m_done)
            check({tag, ".exit"}, int'(bus.row) * D + int'(bus.col), exp_we[exp_we.size() - 1]);
    endtask

    task automatic run_case(input string tag, input int sr, input int sc, input bit hand);
        model_walk(sr, sc, hand);
        act_we.delete();
        act_oe.delete();
        pulse_start(sr, sc, hand);
        wait_idle(tag);
        compare_results(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".row"}, 32'(bus.row), 0);
        check({tag, ".col"}, 32'(bus.col), 0);
        check({tag, ".oe"}, 32'(bus.maze_oe), 0);
        check({tag, ".we"}, 32'(bus.maze_we), 0);
        check({tag, ".busy"}, 32'(bus.busy), 0);
        check({tag, ".done"}, 32'(bus.done), 0);
        check({tag, ".fail"}, 32'(bus.fail), 0);
        check({tag, ".step"}, 32'(bus.step_cnt), 0);
    endtask

    typedef struct {
        int maze; int sr; int sc; bit hand;
        bit done; int step; int we_n; int oe_n; int exit_cell; int first_probe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, we_before, oe_before;
        vecs[0] = '{3, 3, 3, 1'b0, 1'b1, 4, 5, 7, 31, 28};  // corridor, right hand
        vecs[1] = '{3, 3, 3, 1'b1, 1'b1, 3, 4, 5, 24, 26};  // corridor, left hand
        vecs[2] = '{2, 2, 2, 1'b0, 1'b0, 0, 1, 4, 0, 19};   // boxed in
        vecs[3] = '{2, 2, 2, 1'b1, 1'b0, 0, 1, 4, 0, 17};
        vecs[4] = '{0, 3, 3, 1'b0, 1'b0, 7, 7, 7, 0, 28};   // open box: 2x2 loop, step limit
        vecs[5] = '{0, 4, 4, 1'b1, 1'b0, 7, 7, 7, 0, 35};
        vecs[6] = '{0, 0, 5, 1'b0, 1'b1, 0, 1, 0, 5, -1};   // border start

        bus.start = 1'b0; bus.hand_sel = 1'b0; bus.maze_in = 1'b0;
        bus.starting_row = '0; bus.starting_col = '0;
        load_maze(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            load_maze(vecs[i].maze);
            run_case(tag, vecs[i].sr, vecs[i].sc, vecs[i].hand);
            check({tag, ".t_done"}, 32'(bus.done), 32'(vecs[i].done));
            check({tag, ".t_step"}, 32'(bus.step_cnt), vecs[i].step);
            check({tag, ".t_we_n"}, act_we.size(), vecs[i].we_n);
            check({tag, ".t_oe_n"}, act_oe.size(), vecs[i].oe_n);
            if (vecs[i].done)
                check({tag, ".t_exit"}, int'(bus.row) * D + int'(bus.col), vecs[i].exit_cell);
            if (vecs[i].first_probe >= 0 && act_oe.size() > 0)
                check({tag, ".t_first"}, act_oe[0], vecs[i].first_probe);
        end

        // Restart straight out of DONE (last vector ended done at (0,5)).
        load_maze(3);
        model_walk(3, 3, 1'b1);
        act_we.delete(); act_oe.delete();
        pulse_start(3, 3, 1'b1);
        check("restart.done_clr", 32'(bus.done), 0);
        check("restart.busy", 32'(bus.busy), 1);
        wait_idle("restart");
        compare_results("restart");

        // A second start while busy must be ignored.
        model_walk(3, 3, 1'b0);
        act_we.delete(); act_oe.delete();
        pulse_start(3, 3, 1'b0);
        repeat (3) @(negedge clk);
        pulse_start(2, 2, 1'b1);
        wait_idle("ignore");
        compare_results("ignore");

        // Reset during PROBE aborts the walk.
        load_maze(0);
        pulse_start(3, 3, 1'b0);
        n = 0;
        while (!bus.maze_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid.reach_probe", 32'(n < 50), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        rst_n = 1'b1;
        we_before = act_we.size();
        oe_before = act_oe.size();
        repeat (10) @(negedge clk);
        check("rst_mid.no_we", act_we.size(), we_before);
        check("rst_mid.no_oe", act_oe.size(), oe_before);
        check("rst_mid.idle", 32'(bus.busy | bus.done | bus.fail), 0);

        // Random mazes against the reference walker.
        for (int t = 0; t < 30; t++) begin
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++) wall[r][c] = ($urandom_range(99) < 35);
            run_case($sformatf("rnd%0d", t), $urandom_range(D - 1), $urandom_range(D - 1),
                     1'($urandom_range(1)));
        end

        check("oe_we_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
